// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between one master and the data-memory arbiter.
// The master drives the command; the arbiter returns grant and read data.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter in front of a single-port data memory with
// a registered read address. One access at a time; IDLE is always revisited.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                Clk,
    input  logic                rst,
    dmem_arbiter_if.slave       m0,
    dmem_arbiter_if.slave       m1,
    output logic                mem_We,
    output logic [ADDR_W-1:0]   mem_Addr,
    output logic [DATA_W-1:0]   mem_Data_in,
    input  logic [DATA_W-1:0]   mem_Data_out,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic                prio_r, prio_nx_s;
    logic                owner_r, owner_nx_s;
    logic                cmd_we_r, cmd_we_nx_s;
    logic                mem_we_r, mem_we_nx_s;
    logic [ADDR_W-1:0]   addr_r, addr_nx_s;
    logic [DATA_W-1:0]   wdata_r, wdata_nx_s;
    logic [1:0]          gnt_r, gnt_nx_s;
    logic [1:0]          rvalid_r, rvalid_nx_s;
    logic                busy_r;
    logic                win_s;

    // Next-state, arbitration and next values of all registered outputs.
    always_comb begin
        state_nx_s  = state_r;
        prio_nx_s   = prio_r;
        owner_nx_s  = owner_r;
        cmd_we_nx_s = cmd_we_r;
        mem_we_nx_s = 1'b1;
        addr_nx_s   = addr_r;
        wdata_nx_s  = wdata_r;
        gnt_nx_s    = 2'b00;
        rvalid_nx_s = 2'b00;
        win_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (m0.req || m1.req) begin
                    // Contention goes to prio; a lone requester always wins.
                    if (m0.req && m1.req) begin
                        win_s = prio_r;
                    end else begin
                        win_s = m1.req;
                    end
                    owner_nx_s = win_s;
                    prio_nx_s  = ~win_s;
                    if (win_s) begin
                        cmd_we_nx_s = m1.we;
                        addr_nx_s   = m1.addr;
                        wdata_nx_s  = m1.wdata;
                        gnt_nx_s    = 2'b10;
                    end else begin
                        cmd_we_nx_s = m0.we;
                        addr_nx_s   = m0.addr;
                        wdata_nx_s  = m0.wdata;
                        gnt_nx_s    = 2'b01;
                    end
                    mem_we_nx_s = ~cmd_we_nx_s;
                    state_nx_s  = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_we_r) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s  = RDATA;
                    rvalid_nx_s = owner_r ? 2'b10 : 2'b01;
                end
            end
            RDATA: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset raises mem_We at once to kill a pending write.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            prio_r   <= 1'b0;
            owner_r  <= 1'b0;
            cmd_we_r <= 1'b0;
            mem_we_r <= 1'b1;
            addr_r   <= '0;
            wdata_r  <= '0;
            gnt_r    <= 2'b00;
            rvalid_r <= 2'b00;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            prio_r   <= prio_nx_s;
            owner_r  <= owner_nx_s;
            cmd_we_r <= cmd_we_nx_s;
            mem_we_r <= mem_we_nx_s;
            addr_r   <= addr_nx_s;
            wdata_r  <= wdata_nx_s;
            gnt_r    <= gnt_nx_s;
            rvalid_r <= rvalid_nx_s;
            busy_r   <= (state_nx_s != IDLE);
        end
    end

    assign mem_We      = mem_we_r;
    assign mem_Addr    = addr_r;
    assign mem_Data_in = wdata_r;
    assign busy        = busy_r;
    assign m0.gnt      = gnt_r[0];
    assign m1.gnt      = gnt_r[1];
    assign m0.rvalid   = rvalid_r[0];
    assign m1.rvalid   = rvalid_r[1];
    // Memory data is only valid in RDATA, so it is gated rather than re-registered.
    assign m0.rdata    = rvalid_r[0] ? mem_Data_out : '0;
    assign m1.rdata    = rvalid_r[1] ? mem_Data_out : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory
// (registered read address, active-low write strobe).
module tb_dmem_arbiter;
    logic        Clk;
    logic        rst;
    logic        mem_We;
    logic [9:0]  mem_Addr;
    logic [31:0] mem_Data_in;
    logic [31:0] mem_Data_out;
    logic        busy;
    logic        mem_load;
    logic [9:0]  mem_addr_q;
    logic [31:0] mem [0:1023];
    int          n_cmp;
    int          n_err;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0 ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1 ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .Clk          (Clk),
        .rst          (rst),
        .m0           (m0.slave),
        .m1           (m1.slave),
        .mem_We       (mem_We),
        .mem_Addr     (mem_Addr),
        .mem_Data_in  (mem_Data_in),
        .mem_Data_out (mem_Data_out),
        .busy         (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] init_val(input logic [9:0] a);
        case (a)
            10'd0:   init_val = 32'h0000_07D1;
            10'd1:   init_val = 32'h0000_0FA1;
            10'd2:   init_val = 32'h0000_1389;
            default: init_val = 32'h1000_0000 | {22'd0, a};
        endcase
    endfunction

    // Memory model: write when We low, read from the address registered at the edge.
    always @(posedge Clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i[9:0]);
        end else if (!mem_We) begin
            mem[mem_Addr] <= mem_Data_in;
        end
        mem_addr_q <= mem_Addr;
    end
    assign mem_Data_out = mem[mem_addr_q];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_masters();
        m0.req = 1'b0; m0.we = 1'b0; m0.addr = 10'd0; m0.wdata = 32'd0;
        m1.req = 1'b0; m1.we = 1'b0; m1.addr = 10'd0; m1.wdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int g;
        int cyc;
        n_cmp = 0;
        n_err = 0;
        idle_masters();
        mem_load = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        mem_load = 1'b0;
        check_eq("rst_we",   32'(mem_We), 32'd1);
        check_eq("rst_addr", 32'(mem_Addr), 32'd0);
        check_eq("rst_din",  mem_Data_in, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gnt",  32'({m1.gnt, m0.gnt, m1.rvalid, m0.rvalid}), 32'd0);
        rst = 1'b1;

        // m0 reads address 0
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 10'd0;
        tick();
        check_eq("rd0_gnt",  32'({m1.gnt, m0.gnt}), 32'd1);
        check_eq("rd0_we",   32'(mem_We), 32'd1);
        check_eq("rd0_busy", 32'(busy), 32'd1);
        m0.req = 1'b0;
        tick();
        check_eq("rd0_rv",    32'({m1.rvalid, m0.rvalid}), 32'd1);
        check_eq("rd0_data",  m0.rdata, 32'h0000_07D1);
        check_eq("rd0_m1dat", m1.rdata, 32'd0);
        tick();
        check_eq("rd0_idle",  32'({busy, m0.rvalid}), 32'd0);
        check_eq("rd0_zero",  m0.rdata, 32'd0);

        // m1 writes address 3, then m0 reads it back
        m1.req = 1'b1; m1.we = 1'b1; m1.addr = 10'd3; m1.wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("wr3_gnt",  32'({m1.gnt, m0.gnt}), 32'd2);
        check_eq("wr3_we",   32'(mem_We), 32'd0);
        check_eq("wr3_addr", 32'(mem_Addr), 32'd3);
        check_eq("wr3_din",  mem_Data_in, 32'hDEAD_BEEF);
        m1.req = 1'b0;
        tick();
        check_eq("wr3_done", 32'({mem_We, busy}), 32'd2);
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 10'd3;
        tick();
        check_eq("rb3_gnt", 32'(m0.gnt), 32'd1);
        m0.req = 1'b0;
        tick();
        check_eq("rb3_data", m0.rdata, 32'hDEAD_BEEF);
        tick();

        // simultaneous reads after reset: m0 first, then m1
        do_reset();
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 10'd1;
        m1.req = 1'b1; m1.we = 1'b0; m1.addr = 10'd2;
        tick();
        check_eq("both_g0", 32'({m1.gnt, m0.gnt}), 32'd1);
        m0.req = 1'b0;
        tick();
        check_eq("both_d0", m0.rdata, 32'h0000_0FA1);
        check_eq("both_r1", 32'({m1.rvalid, m1.rdata}), 32'd0);
        tick();
        tick();
        check_eq("both_g1", 32'({m1.gnt, m0.gnt}), 32'd2);
        m1.req = 1'b0;
        tick();
        check_eq("both_d1", m1.rdata, 32'h0000_1389);
        check_eq("both_r0", 32'({m0.rvalid, m0.rdata}), 32'd0);
        tick();

        // continuous contention: grants alternate starting at m0 (prio back at 0)
        m0.req = 1'b1; m0.we = 1'b1; m0.addr = 10'd10; m0.wdata = 32'h0A0A_0A0A;
        m1.req = 1'b1; m1.we = 1'b1; m1.addr = 10'd11; m1.wdata = 32'h0B0B_0B0B;
        g = 0;
        cyc = 0;
        while (g < 6 && cyc < 40) begin
            tick();
            cyc++;
            if (m0.gnt || m1.gnt) begin
                check_eq("alt_gnt", 32'({m1.gnt, m0.gnt}), (g % 2 == 0) ? 32'd1 : 32'd2);
                g++;
            end
        end
        check_eq("alt_count", g, 6);
        idle_masters();
        tick();
        check_eq("alt_idle", 32'(busy), 32'd0);

        // reset during ISSUE of a write to address 5
        m0.req = 1'b1; m0.we = 1'b1; m0.addr = 10'd5; m0.wdata = 32'h5555_5555;
        tick();
        check_eq("rw5_we0", 32'(mem_We), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rw5_we1",  32'(mem_We), 32'd1);
        check_eq("rw5_outs", 32'({m0.gnt, m1.gnt, busy, mem_Addr}), 32'd0);
        m0.req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_eq("rw5_post", 32'({busy, m0.gnt, m1.gnt, m0.rvalid, m1.rvalid}), 32'd0);
        check_eq("rw5_din",  mem_Data_in, 32'd0);
        m1.req = 1'b1; m1.we = 1'b0; m1.addr = 10'd5;
        tick();
        m1.req = 1'b0;
        tick();
        check_eq("rw5_mem", m1.rdata, 32'h1000_0005);
        tick();

        // command changes after sampling do not affect the access
        m1.req = 1'b1; m1.we = 1'b0; m1.addr = 10'd7;
        tick();
        check_eq("chg_gnt", 32'(m1.gnt), 32'd1);
        m1.addr = 10'd8; m1.we = 1'b1; m1.wdata = 32'h1234_5678;
        #1;
        check_eq("chg_addr", 32'(mem_Addr), 32'd7);
        check_eq("chg_we",   32'(mem_We), 32'd1);
        m1.req = 1'b0;
        tick();
        check_eq("chg_data", m1.rdata, 32'h1000_0007);
        tick();
        m0.req = 1'b1; m0.we = 1'b1; m0.addr = 10'd9; m0.wdata = 32'hAAAA_0009;
        tick();
        m0.addr = 10'd4; m0.wdata = 32'hBBBB_0004;
        #1;
        check_eq("chgw_addr", 32'(mem_Addr), 32'd9);
        check_eq("chgw_din",  mem_Data_in, 32'hAAAA_0009);
        m0.req = 1'b0;
        tick();
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 10'd9;
        tick();
        m0.req = 1'b0;
        tick();
        check_eq("chgw_mem9", m0.rdata, 32'hAAAA_0009);
        tick();
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 10'd4;
        tick();
        m0.req = 1'b0;
        tick();
        check_eq("chgw_mem4", m0.rdata, 32'h1000_0004);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
